// File: rtl/poker_pkg.sv
// Shared card definitions for the deal engine and the hand-rank evaluator.
// A card code is {rank[3:0], suit[1:0]} and also serves as the deck index.
package poker_pkg;

  typedef logic [5:0] card_t;

  localparam int unsigned RANK_MSB  = 5;
  localparam int unsigned RANK_LSB  = 2;
  localparam int unsigned SUIT_MSB  = 1;
  localparam int unsigned SUIT_LSB  = 0;
  localparam int unsigned NUM_CARDS = 52;
  localparam int unsigned HAND_SIZE = 5;

  typedef enum logic [3:0] {
    RankTwo, RankThree, RankFour, RankFive, RankSix, RankSeven, RankEight,
    RankNine, RankTen, RankJack, RankQueen, RankKing, RankAce
  } rank_e;

  typedef enum logic [1:0] {SuitClubs, SuitDiamonds, SuitHearts, SuitSpades} suit_e;

  typedef enum logic [3:0] {
    HighCard, OnePair, TwoPair, ThreeKind, Straight, Flush, FullHouse, FourKind,
    StraightFlush
  } hand_rank_e;

  typedef enum logic [1:0] {StIdle, StDraw, StEmit, StDone} deal_state_e;

  function automatic rank_e card_rank(input card_t c);
    return rank_e'(c[RANK_MSB:RANK_LSB]);
  endfunction

  function automatic suit_e card_suit(input card_t c);
    return suit_e'(c[SUIT_MSB:SUIT_LSB]);
  endfunction

  // rank < 13 is the same test as code < 52
  function automatic logic card_is_valid(input card_t c);
    return c[RANK_MSB:RANK_LSB] < 4'd13;
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Hand interface between the card dealer (master) and its consumer (slave).
interface card_dealer_if;
  import poker_pkg::*;

  logic                  new_deck;
  logic                  deal;
  logic                  card_ready;
  card_t                 card_out;
  logic                  card_valid;
  card_t [HAND_SIZE-1:0] hand;
  logic                  hand_valid;
  logic                  busy;
  logic [5:0]            cards_left;
  logic                  deal_err;

  modport master (
    input  new_deck, deal, card_ready,
    output card_out, card_valid, hand, hand_valid, busy, cards_left, deal_err
  );

  modport slave (
    output new_deck, deal, card_ready,
    input  card_out, card_valid, hand, hand_valid, busy, cards_left, deal_err
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 0xB400), reset to SEED.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  localparam logic [15:0] TAPS = 16'hB400;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= (state >> 1) ^ (state[0] ? TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Deal engine: draws LFSR candidates, rejects duplicates against the dealt mask,
// and streams five accepted cards per hand over a valid/ready handshake.
module card_dealer
  import poker_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic          clk,
  input logic          rst,
  card_dealer_if.master bus
);

  logic [15:0] lfsr;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  deal_state_e           state_q, state_d;
  logic [NUM_CARDS-1:0]  mask_q, mask_d;
  logic [5:0]            left_q, left_d;
  logic [2:0]            slot_q, slot_d;
  card_t                 card_q, card_d;
  card_t [HAND_SIZE-1:0] hand_q, hand_d;
  logic                  err_q, err_d;

  card_t       cand;
  logic [63:0] mask_ext;
  logic        cand_ok;

  assign cand     = lfsr[5:0];
  assign mask_ext = 64'(mask_q);
  assign cand_ok  = card_is_valid(cand) && !mask_ext[cand];

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    left_d  = left_q;
    slot_d  = slot_q;
    card_d  = card_q;
    hand_d  = hand_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.new_deck) begin
          mask_d = '0;
          left_d = 6'(NUM_CARDS);
        end
        // a same-cycle new_deck refills first, so the deal can never be refused
        if (bus.deal) begin
          if (bus.new_deck || left_q >= 6'(HAND_SIZE)) begin
            slot_d  = '0;
            state_d = StDraw;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StDraw: begin
        if (cand_ok) begin
          card_d  = cand;
          mask_d  = mask_q | (NUM_CARDS'(1) << cand);
          left_d  = left_q - 6'd1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (bus.card_ready) begin
          hand_d[slot_q] = card_q;
          slot_d         = slot_q + 3'd1;
          state_d        = (slot_q == 3'(HAND_SIZE - 1)) ? StDone : StDraw;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= '0;
      left_q  <= 6'(NUM_CARDS);
      slot_q  <= '0;
      card_q  <= '0;
      hand_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      left_q  <= left_d;
      slot_q  <= slot_d;
      card_q  <= card_d;
      hand_q  <= hand_d;
      err_q   <= err_d;
    end
  end

  assign bus.card_out   = card_q;
  assign bus.card_valid = (state_q == StEmit);
  assign bus.hand       = hand_q;
  assign bus.hand_valid = (state_q == StDone);
  assign bus.busy       = (state_q != StIdle);
  assign bus.cards_left = left_q;
  assign bus.deal_err   = err_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: predicts every card from an independent LFSR
// model plus a bench-side dealt mask, and checks handshake timing and counters.
`timescale 1ns/1ps
module tb_card_dealer;
  import poker_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  card_dealer_if bus ();

  card_dealer #(.SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int hv_cnt = 0;

  logic [15:0] m_lfsr;
  logic [51:0] m_mask;
  int          m_left;
  logic [63:0] seen;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  always @(negedge clk) begin
    if (bus.hand_valid === 1'b1) hv_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // First card the DUT should accept when DRAW starts with LFSR value s.
  task automatic predict(input logic [15:0] s, output card_t c, output int n);
    n = 0;
    while ((s[5:0] >= 6'd52 || m_mask[s[5:0]]) && n < 70000) begin
      s = lfsr_step(s);
      n++;
    end
    c = s[5:0];
  endtask

  task automatic deal_hand(input int stall, input bit poke, input bit refill);
    card_t       exp_c;
    card_t       held;
    card_t [4:0] exp_hand;
    int          n;
    int          w;
    int          hv_before;
    hv_before    = hv_cnt;
    bus.deal     = 1'b1;
    bus.new_deck = refill;
    cyc();
    bus.deal     = 1'b0;
    bus.new_deck = 1'b0;
    if (refill) begin
      m_mask = '0;
      m_left = 52;
    end
    check("deal_err_on_deal", 64'(bus.deal_err), 64'(1'b0));
    check("busy_after_deal", 64'(bus.busy), 64'(1'b1));
    for (int k = 0; k < 5; k++) begin
      predict(m_lfsr, exp_c, n);
      bus.card_ready = (stall == 0);
      w = 1;
      cyc();
      while (bus.card_valid !== 1'b1 && w < n + 3) begin
        cyc();
        w++;
      end
      check("card_latency", 64'(w), 64'(n + 1));
      check("card_code", 64'(bus.card_out), 64'(exp_c));
      check("cards_left_dec", 64'(bus.cards_left), 64'(m_left - 1));
      m_mask[exp_c] = 1'b1;
      m_left--;
      seen[exp_c] = 1'b1;
      held = bus.card_out;
      for (int s = 0; s < stall; s++) begin
        if (poke && s == 2) begin
          bus.deal     = 1'b1;
          bus.new_deck = 1'b1;
        end
        cyc();
        bus.deal     = 1'b0;
        bus.new_deck = 1'b0;
        check("valid_held", 64'(bus.card_valid), 64'(1'b1));
        check("card_stable", 64'(bus.card_out), 64'(held));
      end
      bus.card_ready = 1'b1;
      cyc();
      exp_hand[k] = exp_c;
    end
    check("hand_valid_done", 64'(bus.hand_valid), 64'(1'b1));
    check("hand_order", 64'(bus.hand), 64'(exp_hand));
    check("valid_off_done", 64'(bus.card_valid), 64'(1'b0));
    cyc();
    check("hand_valid_pulse", 64'(bus.hand_valid), 64'(1'b0));
    check("busy_idle", 64'(bus.busy), 64'(1'b0));
    check("cards_left_hand", 64'(bus.cards_left), 64'(m_left));
    check("hand_valid_once", 64'(hv_cnt - hv_before), 64'(1));
  endtask

  initial begin
    card_t c0;
    int    n0;
    int    w0;
    rst            = 1'b1;
    bus.deal       = 1'b0;
    bus.new_deck   = 1'b0;
    bus.card_ready = 1'b0;
    m_mask         = '0;
    m_left         = 52;
    seen           = '0;
    #12;
    check("rst_card_valid", 64'(bus.card_valid), 64'(1'b0));
    check("rst_busy", 64'(bus.busy), 64'(1'b0));
    check("rst_cards_left", 64'(bus.cards_left), 64'(52));
    check("rst_hand", 64'(bus.hand), 64'(0));
    check("rst_card_out", 64'(bus.card_out), 64'(0));
    check("rst_deal_err", 64'(bus.deal_err), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // single hand, ready held high
    deal_hand(0, 1'b0, 1'b0);
    check("single_cards_left", 64'(bus.cards_left), 64'(47));
    check("single_distinct", 64'($countones(seen)), 64'(5));

    // backpressure with ignored deal/new_deck pokes while busy
    deal_hand(7, 1'b1, 1'b0);
    check("bp_cards_left", 64'(bus.cards_left), 64'(42));

    // reset in the middle of EMIT
    bus.deal = 1'b1;
    cyc();
    bus.deal = 1'b0;
    predict(m_lfsr, c0, n0);
    w0 = 1;
    cyc();
    while (bus.card_valid !== 1'b1 && w0 < n0 + 3) begin
      cyc();
      w0++;
    end
    check("emit_before_reset", 64'(bus.card_valid), 64'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("midrst_card_valid", 64'(bus.card_valid), 64'(1'b0));
    check("midrst_busy", 64'(bus.busy), 64'(1'b0));
    check("midrst_cards_left", 64'(bus.cards_left), 64'(52));
    check("midrst_hand", 64'(bus.hand), 64'(0));
    check("midrst_card_out", 64'(bus.card_out), 64'(0));
    check("midrst_lfsr", 64'(dut.u_lfsr.state), 64'(SEED));
    @(negedge clk);
    rst    = 1'b0;
    m_mask = '0;
    m_left = 52;
    seen   = '0;
    cyc();

    // exhaustion: ten hands leave two cards
    for (int h = 0; h < 10; h++) deal_hand(0, 1'b0, 1'b0);
    check("exh_cards_left", 64'(bus.cards_left), 64'(2));
    check("exh_distinct", 64'($countones(seen)), 64'(50));
    bus.deal = 1'b1;
    cyc();
    bus.deal = 1'b0;
    check("refuse_deal_err", 64'(bus.deal_err), 64'(1'b1));
    check("refuse_busy", 64'(bus.busy), 64'(1'b0));
    cyc();
    check("refuse_err_pulse", 64'(bus.deal_err), 64'(1'b0));
    check("refuse_no_valid", 64'(bus.card_valid), 64'(1'b0));
    cyc();
    check("refuse_still_idle", 64'(bus.busy), 64'(1'b0));
    check("refuse_cards_left", 64'(bus.cards_left), 64'(2));

    // refill and deal in the same cycle
    deal_hand(0, 1'b0, 1'b1);
    check("refill_cards_left", 64'(bus.cards_left), 64'(47));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
